// File: rtl/silife_max7219_rx.sv
// silife_max7219_rx: MAX7219 daisy-chain SPI receiver that decodes each frame into
// per-device digit storage and device-0 configuration registers.
module silife_max7219_rx #(
    parameter int CHAIN    = 16,
    parameter int DEV_BITS = $clog2(CHAIN)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_cs,
    input  logic                i_sck,
    input  logic                i_mosi,
    input  logic [DEV_BITS-1:0] i_rd_dev,
    input  logic [2:0]          i_rd_digit,
    output logic [7:0]          o_rd_data,
    output logic [3:0]          o_intensity,
    output logic [2:0]          o_scan_limit,
    output logic                o_shutdown_n,
    output logic                o_display_test,
    output logic                o_busy,
    output logic                o_frame,
    output logic                o_error
);
    localparam int FRAME = 16 * CHAIN;
    localparam int CW    = $clog2(FRAME + 2);
    localparam logic [CW-1:0] FULL = CW'(FRAME);
    localparam logic [CW-1:0] SAT  = CW'(FRAME + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t              state, state_next;
    logic [1:0]          cs_sync, sck_sync, mosi_sync;
    logic                cs_prev, sck_prev;
    logic                cs_q, mosi_q, sck_rise, cs_fall, cs_rise;
    logic [FRAME-1:0]    shift;
    logic [CW-1:0]       count, count_inc;
    logic [DEV_BITS-1:0] dev;
    logic                last_dev, cs_low_seen, frame_next, error_next;
    logic [3:0]          addr, addr_m1;
    logic [7:0]          data;
    logic [7:0]          digits [CHAIN][8];

    assign cs_q      = cs_sync[1];
    assign mosi_q    = mosi_sync[1];
    assign sck_rise  = sck_sync[1] & ~sck_prev;
    assign cs_fall   = cs_prev & ~cs_q;
    assign cs_rise   = ~cs_prev & cs_q;
    assign count_inc = (sck_rise && count != SAT) ? count + 1'b1 : count;
    assign last_dev  = dev == DEV_BITS'(CHAIN - 1);
    assign addr      = shift[{dev, 4'd8} +: 4];
    assign data      = shift[{dev, 4'd0} +: 8];
    assign addr_m1   = addr - 4'd1;
    assign o_busy    = state == COMMIT;
    assign o_rd_data = digits[i_rd_dev][i_rd_digit];

    always_comb begin
        state_next = state;
        frame_next = 1'b0;
        error_next = 1'b0;
        case (state)
            IDLE:   state_next = cs_fall ? SHIFT : IDLE;
            SHIFT: if (cs_rise) begin
                state_next = count_inc == FULL ? COMMIT : IDLE;
                error_next = count_inc != FULL;
            end
            COMMIT: if (last_dev) begin
                state_next = IDLE;
                frame_next = 1'b1;
                error_next = cs_low_seen | ~cs_q;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            o_frame <= 1'b0;
            o_error <= 1'b0;
        end else begin
            state   <= state_next;
            o_frame <= frame_next;
            o_error <= error_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_sync     <= 2'b11;
            sck_sync    <= 2'b00;
            mosi_sync   <= 2'b00;
            cs_prev     <= 1'b1;
            sck_prev    <= 1'b0;
            shift       <= '0;
            count       <= '0;
            dev         <= '0;
            cs_low_seen <= 1'b0;
        end else begin
            cs_sync     <= {cs_sync[0], i_cs};
            sck_sync    <= {sck_sync[0], i_sck};
            mosi_sync   <= {mosi_sync[0], i_mosi};
            cs_prev     <= cs_q;
            sck_prev    <= sck_sync[1];
            dev         <= (state == COMMIT && !last_dev) ? dev + 1'b1 : '0;
            cs_low_seen <= state == COMMIT && (cs_low_seen | ~cs_q);
            if (state == IDLE && cs_fall)
                count <= '0;
            else if (state == SHIFT)
                count <= count_inc;
            if (state == SHIFT && sck_rise)
                shift <= {shift[FRAME-2:0], mosi_q};
        end
    end

    // Configuration registers only track device 0; other devices' config words are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_intensity    <= '0;
            o_scan_limit   <= '0;
            o_shutdown_n   <= 1'b0;
            o_display_test <= 1'b0;
            for (int d = 0; d < CHAIN; d++)
                for (int g = 0; g < 8; g++)
                    digits[d][g] <= '0;
        end else if (state == COMMIT) begin
            if (addr >= 4'h1 && addr <= 4'h8)
                digits[dev][addr_m1[2:0]] <= data;
            if (dev == '0) begin
                if (addr == 4'hA) o_intensity    <= data[3:0];
                if (addr == 4'hB) o_scan_limit   <= data[2:0];
                if (addr == 4'hC) o_shutdown_n   <= data[0];
                if (addr == 4'hF) o_display_test <= data[0];
            end
        end
    end
endmodule

// File: tb/tb_silife_max7219_rx.sv
// tb_silife_max7219_rx: table-driven config frames plus randomized frames checked
// against a word-level model of the MAX7219 chain.
module tb_silife_max7219_rx;
    logic       clk = 1'b0;
    logic       reset, cs, sck, mosi;
    logic [3:0] rd_dev;
    logic [2:0] rd_digit;
    logic [7:0] rd_data;
    logic [3:0] intensity;
    logic [2:0] scan_limit;
    logic       shutdown_n, display_test, busy, frame, error;

    silife_max7219_rx dut (
        .clk(clk), .reset(reset), .i_cs(cs), .i_sck(sck), .i_mosi(mosi),
        .i_rd_dev(rd_dev), .i_rd_digit(rd_digit), .o_rd_data(rd_data),
        .o_intensity(intensity), .o_scan_limit(scan_limit), .o_shutdown_n(shutdown_n),
        .o_display_test(display_test), .o_busy(busy), .o_frame(frame), .o_error(error)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int n_frame = 0, n_error = 0, n_busy = 0;

    always @(negedge clk) begin
        if (frame) n_frame++;
        if (error) n_error++;
        if (busy)  n_busy++;
    end

    logic [15:0] w [16];
    logic        q [$];
    logic [7:0]  md [16][8];
    logic [3:0]  mi;
    logic [2:0]  ms;
    logic        msh, mt;

    typedef struct {
        logic [15:0] w0, wo;
        logic [3:0]  ei;
        logic [2:0]  es;
        logic        esh, et;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr();
        n_frame = 0;
        n_error = 0;
        n_busy  = 0;
    endtask

    function automatic void model_apply();
        for (int d = 0; d < 16; d++) begin
            int a = int'(w[d][11:8]);
            if (a >= 1 && a <= 8) md[d][a-1] = w[d][7:0];
            if (d == 0 && a == 10) mi  = w[d][3:0];
            if (d == 0 && a == 11) ms  = w[d][2:0];
            if (d == 0 && a == 12) msh = w[d][0];
            if (d == 0 && a == 15) mt  = w[d][0];
        end
    endfunction

    task automatic build(input int delta);
        q.delete();
        for (int d = 15; d >= 0; d--)
            for (int b = 15; b >= 0; b--)
                q.push_back(w[d][b]);
        if (delta < 0) void'(q.pop_back());
        if (delta > 0) q.push_back(1'b1);
    endtask

    task automatic drive(input int n);
        for (int i = 0; i < n; i++) begin
            mosi = q[i];
            repeat (4) @(posedge clk);
            sck = 1'b1;
            repeat (4) @(posedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic xmit();
        cs = 1'b0;
        repeat (4) @(posedge clk);
        drive(q.size());
        repeat (4) @(posedge clk);
        cs = 1'b1;
    endtask

    task automatic send_frame(input int delta);
        build(delta);
        xmit();
        repeat (40) @(posedge clk);
    endtask

    task automatic check_digits(input string tag);
        for (int d = 0; d < 16; d++)
            for (int g = 0; g < 8; g++) begin
                rd_dev   = 4'(d);
                rd_digit = 3'(g);
                #1;
                chk($sformatf("%s dig[%0d][%0d]", tag, d, g), 32'(rd_data), 32'(md[d][g]));
            end
    endtask

    task automatic check_cfg(input string tag);
        chk({tag, " intensity"}, 32'(intensity), 32'(mi));
        chk({tag, " scan"}, 32'(scan_limit), 32'(ms));
        chk({tag, " shutdown"}, 32'(shutdown_n), 32'(msh));
        chk({tag, " test"}, 32'(display_test), 32'(mt));
    endtask

    task automatic rand_digit_words();
        for (int d = 0; d < 16; d++)
            w[d] = {4'($urandom), 4'($urandom_range(1, 8)), 8'($urandom)};
    endtask

    initial begin
        tbl[0] = '{16'h0A07, 16'h0A0F, 4'h7, 3'd0, 1'b1, 1'b0};
        tbl[1] = '{16'h0B05, 16'h0B02, 4'h7, 3'd5, 1'b1, 1'b0};
        tbl[2] = '{16'h0F01, 16'h0F00, 4'h7, 3'd5, 1'b1, 1'b1};
        tbl[3] = '{16'hFC00, 16'h0C01, 4'h7, 3'd5, 1'b0, 1'b1};
        tbl[4] = '{16'h0DFF, 16'h0A03, 4'h7, 3'd5, 1'b0, 1'b1};
        tbl[5] = '{16'h0F00, 16'h0C01, 4'h7, 3'd5, 1'b0, 1'b0};
        tbl[6] = '{16'h5A1C, 16'h0000, 4'hC, 3'd5, 1'b0, 1'b0};
        for (int d = 0; d < 16; d++)
            for (int g = 0; g < 8; g++)
                md[d][g] = 8'h00;
        mi = '0; ms = '0; msh = 1'b0; mt = 1'b0;
        reset = 1'b0; cs = 1'b1; sck = 1'b0; mosi = 1'b0; rd_dev = '0; rd_digit = '0;
        repeat (3) @(posedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);

        // reset in the middle of a SHIFT window
        rand_digit_words();
        build(0);
        cs = 1'b0;
        repeat (4) @(posedge clk);
        drive(50);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        cs = 1'b1;
        repeat (3) @(posedge clk);
        clr();
        reset = 1'b1;
        repeat (20) @(posedge clk);
        chk("reset frame pulses", 32'(n_frame), 0);
        chk("reset error pulses", 32'(n_error), 0);
        chk("reset busy", 32'(n_busy), 0);
        check_cfg("reset");
        check_digits("reset");

        // all devices shutdown=1
        for (int d = 0; d < 16; d++) w[d] = 16'h0C01;
        clr();
        send_frame(0);
        model_apply();
        chk("shutdown busy cycles", 32'(n_busy), 16);
        chk("shutdown frame pulses", 32'(n_frame), 1);
        chk("shutdown error pulses", 32'(n_error), 0);
        chk("shutdown_n set", 32'(shutdown_n), 1);

        for (int t = 0; t < 7; t++) begin
            w[0] = tbl[t].w0;
            for (int d = 1; d < 16; d++) w[d] = tbl[t].wo;
            clr();
            send_frame(0);
            model_apply();
            chk($sformatf("tbl%0d frame", t), 32'(n_frame), 1);
            chk($sformatf("tbl%0d error", t), 32'(n_error), 0);
            chk($sformatf("tbl%0d intensity", t), 32'(intensity), 32'(tbl[t].ei));
            chk($sformatf("tbl%0d scan", t), 32'(scan_limit), 32'(tbl[t].es));
            chk($sformatf("tbl%0d shutdown", t), 32'(shutdown_n), 32'(tbl[t].esh));
            chk($sformatf("tbl%0d test", t), 32'(display_test), 32'(tbl[t].et));
        end
        check_cfg("tbl model");

        // device k writes {k,k} to digit register 3
        for (int k = 0; k < 16; k++) w[k] = {4'h0, 4'h3, 4'(k), 4'(k)};
        clr();
        send_frame(0);
        model_apply();
        for (int k = 0; k < 16; k++) begin
            rd_dev = 4'(k);
            rd_digit = 3'd2;
            #1;
            chk($sformatf("digit2 dev%0d", k), 32'(rd_data), 32'(k * 17));
        end
        check_digits("digit2");

        for (int r = 0; r < 4; r++) begin
            for (int d = 0; d < 16; d++) w[d] = 16'($urandom);
            clr();
            send_frame(0);
            model_apply();
            chk($sformatf("rand%0d frame", r), 32'(n_frame), 1);
            chk($sformatf("rand%0d error", r), 32'(n_error), 0);
            check_cfg($sformatf("rand%0d", r));
            check_digits($sformatf("rand%0d", r));
        end

        for (int s = 0; s < 2; s++) begin
            rand_digit_words();
            clr();
            send_frame(s == 0 ? -1 : 1);
            chk($sformatf("badlen%0d error", s), 32'(n_error), 1);
            chk($sformatf("badlen%0d frame", s), 32'(n_frame), 0);
            check_digits($sformatf("badlen%0d", s));
        end

        // cs pulse during COMMIT, then a fresh valid frame
        rand_digit_words();
        build(0);
        clr();
        xmit();
        for (int i = 0; i < 20 && !busy; i++) begin
            @(posedge clk);
            #1;
        end
        chk("cspulse busy seen", 32'(busy), 1);
        repeat (2) @(posedge clk);
        cs = 1'b0;
        repeat (3) @(posedge clk);
        cs = 1'b1;
        repeat (40) @(posedge clk);
        model_apply();
        chk("cspulse frame", 32'(n_frame), 1);
        chk("cspulse error", 32'(n_error), 1);
        check_digits("cspulse");
        rand_digit_words();
        clr();
        send_frame(0);
        model_apply();
        chk("after cspulse frame", 32'(n_frame), 1);
        chk("after cspulse error", 32'(n_error), 0);
        check_digits("after cspulse");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/silife_max7219_rx.md
Name: silife_max7219_rx

Overview:
- SPI receiver for the MAX7219 daisy-chain protocol: the display-side counterpart of the silife MAX7219 driver.
- Deserialises one CHAIN×16-bit frame per CS window, decodes each 16-bit word as a MAX7219 register write, and stores digit data and device-0 configuration.
- Used as a display model in grid-level benches and as an on-chip loopback monitor of spi_cs/spi_sck/spi_mosi.

Parameters:
- CHAIN, 16, number of MAX7219 devices in the chain; a frame is 16*CHAIN bits.
- DEV_BITS, $clog2(CHAIN), width of the device index.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- i_cs  input  1  SPI chip select, active low, asynchronous to clk
- i_sck  input  1  SPI clock, asynchronous, mode 0 (sample on rising edge)
- i_mosi  input  1  SPI data, MSB first
- i_rd_dev  input  DEV_BITS  read-port device index
- i_rd_digit  input  3  read-port digit index (0 = digit register 1)
- o_rd_data  output  8  stored digit byte, combinational from i_rd_dev/i_rd_digit
- o_intensity  output  4  device-0 intensity register (0xA)
- o_scan_limit  output  3  device-0 scan-limit register (0xB)
- o_shutdown_n  output  1  device-0 shutdown register bit 0 (0xC)
- o_display_test  output  1  device-0 display-test bit 0 (0xF)
- o_busy  output  1  high while the COMMIT state is active
- o_frame  output  1  one-cycle pulse after a successful commit
- o_error  output  1  one-cycle pulse when a frame is rejected

Behaviour:
- Reset (reset=0, asynchronous):
  - digit store, o_intensity, o_scan_limit, o_shutdown_n and o_display_test all clear to 0. o_shutdown_n=0 matches MAX7219 power-up.
  - o_busy, o_frame and o_error are 0. The shift register and bit counter clear. The state is IDLE.
  - All synchroniser flops clear to idle levels: cs=1, sck=0, mosi=0.
- Synchronisation:
  - i_cs, i_sck and i_mosi each pass through a 2-flop synchroniser.
  - An SCK rising edge is detected when the synchronised sck is 1 and its delayed copy is 0.
  - clk must be at least 4× the SCK frequency.
- IDLE:
  - Synchronised cs going 1→0 moves the FSM to SHIFT and clears the bit counter.
  - SCK edges while cs=1 are ignored.
- SHIFT:
  - On each SCK rising edge, the synchronised mosi value shifts into bit 0 of a 16*CHAIN shift register.
  - The bit counter increments and saturates at 16*CHAIN+1.
  - Synchronised cs going 0→1 ends the window:
    - count == 16*CHAIN: go to COMMIT.
    - otherwise (short or long frame): pulse o_error, leave storage unchanged, return to IDLE.
- Frame mapping:
  - The last 16 bits received belong to device 0; the first 16 belong to device CHAIN-1.
  - Word k = shift[16k+15:16k]. Address = bits[11:8], data = bits[7:0]. Bits[15:12] are ignored.
- COMMIT:
  - Processes one device per clk, k = 0..CHAIN-1; o_busy=1 throughout.
  - Address 0x1..0x8: store data into digit (address-1) of device k.
  - Address 0x0 (no-op) and 0x9 (decode mode): no store.
  - Addresses 0xA, 0xB, 0xC, 0xF: update the matching config output only when k == 0; ignored for other devices.
  - Addresses 0xD and 0xE: ignored.
  - After k = CHAIN-1, the next cycle pulses o_frame and returns to IDLE.
  - Latency: CS rising pin edge → o_frame is at most 3 + CHAIN + 1 clk.
- CS activity during COMMIT:
  - A cs falling edge is not acted on; COMMIT completes normally.
  - The FSM then returns to IDLE and waits for a fresh falling edge.
  - Any bits clocked in meanwhile are lost. o_error pulses once when COMMIT ends if cs was seen low during COMMIT.
- Read port: o_rd_data is combinational and always reflects committed state. Stored digit data changes only in COMMIT, one device per cycle.
- Simultaneous events: a final SCK edge coincident with the cs rise (same synchronised cycle) is counted before the length check.

Test Plan:
- Reset with reset=0 mid-SHIFT, release, read all 128 digits → every o_rd_data is 0x00, o_shutdown_n=0, no o_frame/o_error pulse.
- One 256-bit frame with every word 0x0C01, SCK=clk/8 → o_busy high 16 cycles, o_frame pulse once, o_shutdown_n=1.
- Frame where device k's word = {4'h0, 4'h3, 4'hk, 4'hk} → read dev k, digit 2 returns 8'hkk for all k=0..15; other digits remain 0.
- Frame with device 0 = 0x0A07 and devices 1..15 = 0x0A0F → o_intensity=7.
- 255-bit frame → o_error single pulse, no o_frame, previous digit contents unchanged. Repeat with a 257-bit frame → same result.
- CS pulsed low 2 clk after commit starts, then a valid frame → first commit completes with o_frame, o_error pulses once, second frame commits correctly.
